// File: rtl/seg7_pkg.sv
// seg7_pkg: segment patterns, BCD codes and FSM states shared by the seg7 scan reader.
package seg7_pkg;
  localparam logic [9:0][6:0] SEG_DIGIT = {
    7'b0000100, 7'b0000000, 7'b0001111, 7'b0100000, 7'b0100100,
    7'b1001100, 7'b0000110, 7'b0010010, 7'b1001111, 7'b0000001
  };
  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [3:0] BCD_INVALID = 4'hE;
  localparam logic [3:0] BCD_BLANK = 4'hF;
  typedef enum logic {COLLECT, HOLD} state_t;
endpackage

// File: rtl/seg7_to_bcd.sv
// seg7_to_bcd: active-low 7-segment pattern to BCD nibble; SEG7_SCAN_READER_BLANK_EN makes all-off legal.
module seg7_to_bcd
  import seg7_pkg::*;
(
  input  logic [6:0] seg,
  output logic [3:0] bcd,
  output logic       err
);
  always_comb begin
    bcd = BCD_INVALID;
    err = 1'b1;
    for (int i = 0; i < 10; i++)
      if (seg == SEG_DIGIT[i]) begin
        bcd = 4'(i);
        err = 1'b0;
      end
`ifdef SEG7_SCAN_READER_BLANK_EN
    if (seg == SEG_BLANK) begin
      bcd = BCD_BLANK;
      err = 1'b0;
    end
`else
`endif
  end
endmodule

// File: rtl/seg7_scan_reader.sv
// seg7_scan_reader: debounced multiplexed 7-seg bus reader delivering BCD frames over valid/ready.
// Optional SEG7_SCAN_READER_BLANK_EN accepts blanked digits (handled in seg7_to_bcd).
module seg7_scan_reader
  import seg7_pkg::*;
#(
  parameter int DIGITS        = 4,
  parameter int STABLE_CYCLES = 4
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic [6:0]            i_segments,
  input  logic [DIGITS-1:0]     i_digit_en,
  input  logic                  i_ready,
  output logic                  o_valid,
  output logic [4*DIGITS-1:0]   o_bcd,
  output logic [DIGITS-1:0]     o_err,
  output logic                  o_overrun
);
  logic [DIGITS-1:0]   s_en, p_en, mask, stage_err;
  logic [6:0]          s_seg, p_seg;
  logic [7:0]          cnt, cnt_n;
  logic [4*DIGITS-1:0] stage_bcd;
  logic [3:0]          nib;
  logic                nerr, hot, same, cap, full, hold, load, ovr_n;
  state_t              state, state_n;

  seg7_to_bcd u_dec (.seg(s_seg), .bcd(nib), .err(nerr));

  assign hot  = (s_en != '0) && ((s_en & (s_en - DIGITS'(1))) == '0);
  assign same = {s_en, s_seg} == {p_en, p_seg};
  // Capture fires only on the single edge the counter reaches the threshold.
  assign cap  = hot && same && (cnt == 8'(STABLE_CYCLES - 1));
  assign full = &mask;
  assign hold = state == HOLD;
  assign o_valid = hold;

  always_comb begin
    cnt_n   = (hot && same) ? ((cnt == 8'(STABLE_CYCLES)) ? cnt : cnt + 8'd1) : (hot ? 8'd1 : 8'd0);
    load    = full && (!hold || i_ready);
    state_n = load ? HOLD : ((hold && i_ready) ? COLLECT : state);
    ovr_n   = (hold && i_ready) ? 1'b0 : ((hold && full) ? 1'b1 : o_overrun);
  end

  always_ff @(posedge i_clk or posedge i_rst)
    if (i_rst) state <= COLLECT;
    else state <= state_n;

  always_ff @(posedge i_clk or posedge i_rst)
    if (i_rst) begin
      s_en      <= '0;
      s_seg     <= '0;
      p_en      <= '0;
      p_seg     <= '0;
      cnt       <= '0;
      mask      <= '0;
      stage_bcd <= '0;
      stage_err <= '0;
      o_bcd     <= '0;
      o_err     <= '0;
      o_overrun <= 1'b0;
    end else begin
      s_en      <= i_digit_en;
      s_seg     <= i_segments;
      p_en      <= s_en;
      p_seg     <= s_seg;
      cnt       <= cnt_n;
      o_overrun <= ovr_n;
      // A completed frame is either consumed or dropped, so the mask always restarts.
      mask      <= (full ? '0 : mask) | (cap ? s_en : '0);
      for (int k = 0; k < DIGITS; k++)
        if (cap && s_en[k]) begin
          stage_bcd[4*k +: 4] <= nib;
          stage_err[k]        <= nerr;
        end
      if (load) begin
        o_bcd <= stage_bcd;
        o_err <= stage_err;
      end
    end
endmodule

// File: tb/tb_seg7_scan_reader.sv
// tb_seg7_scan_reader: directed self-checking bench for seg7_scan_reader (DIGITS=4, STABLE_CYCLES=4).
module tb_seg7_scan_reader;
  logic        i_clk = 1'b0;
  logic        i_rst = 1'b1;
  logic [6:0]  i_segments = 7'h7f;
  logic [3:0]  i_digit_en = '0;
  logic        i_ready = 1'b0;
  logic        o_valid;
  logic [15:0] o_bcd;
  logic [3:0]  o_err;
  logic        o_overrun;
  int checks = 0;
  int fails = 0;
  logic [6:0] pat [10] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100,
                           7'b0100100, 7'b0100000, 7'b0001111, 7'b0000000, 7'b0000100};

  seg7_scan_reader #(.DIGITS(4), .STABLE_CYCLES(4)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_segments(i_segments), .i_digit_en(i_digit_en),
    .i_ready(i_ready), .o_valid(o_valid), .o_bcd(o_bcd), .o_err(o_err), .o_overrun(o_overrun)
  );

  always #5 i_clk = ~i_clk;

  task automatic step(input int n);
    repeat (n) begin
      @(posedge i_clk);
      #1;
    end
  endtask

  task automatic idle();
    i_digit_en = '0;
    i_segments = 7'h7f;
  endtask

  task automatic drive(input int k, input logic [6:0] seg, input int n);
    i_digit_en = 4'(1 << k);
    i_segments = seg;
    step(n);
  endtask

  task automatic scan(input logic [6:0] s0, input logic [6:0] s1, input logic [6:0] s2, input logic [6:0] s3);
    drive(0, s0, 4);
    drive(1, s1, 4);
    drive(2, s2, 4);
    drive(3, s3, 4);
    idle();
  endtask

  task automatic do_reset();
    i_rst = 1'b1;
    i_ready = 1'b0;
    idle();
    step(1);
    i_rst = 1'b0;
    step(1);
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if ({o_valid, o_bcd, o_err, o_overrun} !== 22'd0) begin
      fails++;
      $display("FAIL reset_outputs: got %h want 0", {o_valid, o_bcd, o_err, o_overrun});
    end
    step(1);
    i_rst = 1'b0;
    step(1);
    scan(pat[1], pat[2], pat[3], pat[4]);
    drive(0, pat[5], 4);
    drive(1, pat[6], 4);
    drive(2, pat[7], 2);
    #2 i_rst = 1'b1;
    #1;
    checks++;
    if ({o_valid, o_bcd, o_err, o_overrun} !== 22'd0) begin
      fails++;
      $display("FAIL reset_async_clear: got %h want 0", {o_valid, o_bcd, o_err, o_overrun});
    end
    step(1);
    i_rst = 1'b0;
    idle();
    step(1);
    drive(2, pat[7], 4);
    drive(3, pat[8], 4);
    idle();
    step(4);
    checks++;
    if (o_valid !== 1'b0) begin
      fails++;
      $display("FAIL reset_partial_discard: valid got %b want 0", o_valid);
    end
    scan(pat[5], pat[6], pat[7], pat[8]);
    step(2);
    checks++;
    if (o_valid !== 1'b1 || o_bcd !== 16'h8765) begin
      fails++;
      $display("FAIL reset_new_frame: valid %b bcd %h want 1 8765", o_valid, o_bcd);
    end
  endtask

  task automatic test_nominal();
    do_reset();
    scan(pat[1], pat[2], pat[3], pat[4]);
    step(1);
    checks++;
    if (o_valid !== 1'b0) begin
      fails++;
      $display("FAIL nominal_early_valid: got %b want 0", o_valid);
    end
    step(1);
    checks++;
    if (o_valid !== 1'b1) begin
      fails++;
      $display("FAIL nominal_valid: got %b want 1", o_valid);
    end
    checks++;
    if (o_bcd !== 16'h4321) begin
      fails++;
      $display("FAIL nominal_bcd: got %h want 4321", o_bcd);
    end
    checks++;
    if (o_err !== 4'b0000) begin
      fails++;
      $display("FAIL nominal_err: got %b want 0000", o_err);
    end
    i_ready = 1'b1;
    step(1);
    i_ready = 1'b0;
    checks++;
    if (o_valid !== 1'b0) begin
      fails++;
      $display("FAIL nominal_consume: valid got %b want 0", o_valid);
    end
  endtask

  task automatic test_glitch();
    do_reset();
    drive(0, pat[1], 4);
    drive(1, pat[9], 3);
    drive(2, pat[3], 4);
    drive(3, pat[4], 4);
    idle();
    step(3);
    checks++;
    if (o_valid !== 1'b0) begin
      fails++;
      $display("FAIL glitch_no_capture: valid got %b want 0", o_valid);
    end
    drive(1, pat[5], 4);
    idle();
    step(2);
    checks++;
    if (o_valid !== 1'b1 || o_bcd !== 16'h4351) begin
      fails++;
      $display("FAIL glitch_recover: valid %b bcd %h want 1 4351", o_valid, o_bcd);
    end
  endtask

  task automatic test_invalid();
    do_reset();
    scan(pat[1], pat[2], 7'b1111110, pat[4]);
    step(2);
    checks++;
    if (o_valid !== 1'b1 || o_bcd !== 16'h4E21) begin
      fails++;
      $display("FAIL invalid_bcd: valid %b bcd %h want 1 4e21", o_valid, o_bcd);
    end
    checks++;
    if (o_err !== 4'b0100) begin
      fails++;
      $display("FAIL invalid_err: got %b want 0100", o_err);
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    scan(pat[1], pat[2], pat[3], pat[4]);
    step(2);
    scan(pat[5], pat[6], pat[7], pat[8]);
    step(3);
    checks++;
    if (o_valid !== 1'b1 || o_bcd !== 16'h4321) begin
      fails++;
      $display("FAIL bp_hold: valid %b bcd %h want 1 4321", o_valid, o_bcd);
    end
    checks++;
    if (o_overrun !== 1'b1) begin
      fails++;
      $display("FAIL bp_overrun_set: got %b want 1", o_overrun);
    end
    i_ready = 1'b1;
    step(1);
    i_ready = 1'b0;
    checks++;
    if (o_valid !== 1'b0) begin
      fails++;
      $display("FAIL bp_consume_valid: got %b want 0", o_valid);
    end
    checks++;
    if (o_overrun !== 1'b0) begin
      fails++;
      $display("FAIL bp_overrun_clear: got %b want 0", o_overrun);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    scan(pat[1], pat[2], pat[3], pat[4]);
    step(2);
    scan(pat[5], pat[6], pat[7], pat[8]);
    step(1);
    i_ready = 1'b1;
    step(1);
    i_ready = 1'b0;
    checks++;
    if (o_valid !== 1'b1 || o_bcd !== 16'h8765) begin
      fails++;
      $display("FAIL b2b_reload: valid %b bcd %h want 1 8765", o_valid, o_bcd);
    end
    checks++;
    if (o_overrun !== 1'b0) begin
      fails++;
      $display("FAIL b2b_overrun: got %b want 0", o_overrun);
    end
  endtask

  task automatic test_blank();
    logic [15:0] exp_bcd;
    logic [3:0]  exp_err;
`ifdef SEG7_SCAN_READER_BLANK_EN
    exp_bcd = 16'hF321;
    exp_err = 4'b0000;
`else
    exp_bcd = 16'hE321;
    exp_err = 4'b1000;
`endif
    do_reset();
    scan(pat[1], pat[2], pat[3], 7'b1111111);
    step(2);
    checks++;
    if (o_valid !== 1'b1 || o_bcd !== exp_bcd) begin
      fails++;
      $display("FAIL blank_bcd: valid %b bcd %h want 1 %h", o_valid, o_bcd, exp_bcd);
    end
    checks++;
    if (o_err !== exp_err) begin
      fails++;
      $display("FAIL blank_err: got %b want %b", o_err, exp_err);
    end
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_glitch();
    test_invalid();
    test_backpressure();
    test_back_to_back();
    test_blank();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule

// File: doc/seg7_scan_reader.md
Name: seg7_scan_reader

Overview:
- Reads a multiplexed, active-low 7-segment display bus: one shared segment bus plus one-hot digit enables.
- Rejects glitching samples, maps each stable segment pattern back to a BCD digit, and assembles one frame of all digits.
- Delivers each frame through a valid/ready handshake.
- Sits on the board-test and loopback path as the inverse of the BCD-to-segment display driver.

Parameters:
- DIGITS, 4, number of multiplexed digits (1..8).
- STABLE_CYCLES, 4, consecutive identical cycles required before a sample is captured (2..255).

Ports:
- i_clk  input  1  clock, rising edge.
- i_rst  input  1  reset, asynchronous, active-high.
- i_segments  input  7  active-low segments, bit6=a ... bit0=g.
- i_digit_en  input  DIGITS  one-hot digit select, active-high.
- i_ready  input  1  consumer accepts the frame.
- o_valid  output  1  frame available.
- o_bcd  output  4*DIGITS  digit k at bits [4k+3:4k].
- o_err  output  DIGITS  per-digit invalid-pattern flag, qualified by o_valid.
- o_overrun  output  1  sticky; a completed frame was dropped.

Behaviour:
- Reset (async, active-high):
  - o_valid=0, o_bcd=0, o_err=0, o_overrun=0.
  - Stability counter=0, sample registers=0, capture mask=0, FSM=COLLECT.
  - A reset asserted mid-frame discards all partial captures.
- Sampling:
  - Each cycle, {i_digit_en, i_segments} is registered and compared with the previous sample.
  - Equal and one-hot: the counter increments, saturating at STABLE_CYCLES.
  - Otherwise: the counter is set to 1, or to 0 if the enable is not one-hot.
- Capture:
  - Occurs on the edge where the counter goes from STABLE_CYCLES-1 to STABLE_CYCLES, i.e. exactly once per stable dwell.
  - Stores the decoded nibble and error bit into staging slot k and sets mask[k].
  - Re-capturing an already-set slot overwrites it.
- Pattern map:
  - 0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100, 5=0100100, 6=0100000, 7=0001111, 8=0000000, 9=0000100.
  - Any other pattern gives nibble 4'hE with the error bit set.
- Enable handling:
  - i_digit_en of zero or multi-hot is ignored.
  - The counter is held at 0 while the enable is not one-hot.
- Frame complete: the mask becomes all-ones. The mask clears on the same edge that the frame is consumed or dropped.
- FSM COLLECT (o_valid=0):
  - Frame complete loads o_bcd/o_err one edge after the final capture.
  - o_valid goes to 1 and the FSM moves to HOLD.
- FSM HOLD (o_valid=1): o_bcd/o_err are stable. Collection of the next frame continues.
  - i_ready=1 and no new frame: o_valid drops; move to COLLECT.
  - i_ready=1 and a new frame completes the same cycle: the new frame loads and o_valid stays 1.
  - i_ready=0 and a new frame completes: the new frame is dropped, o_overrun=1, and the mask clears.
- o_overrun clears on the next accepted handshake (o_valid && i_ready).
- Latency, digit 0 enable to frame out: DIGITS*STABLE_CYCLES + 2 cycles minimum for back-to-back digits (1 sample register + 1 output register).

Optional Feature:
- Macro: SEG7_SCAN_READER_BLANK_EN.
- Defined: the all-off pattern 1111111 maps to nibble 4'hF with error bit 0, so blanked leading digits are legal.
- Undefined: 1111111 is an invalid pattern and maps to 4'hE with the error bit set.

Decomposition:
- Package seg7_pkg holds:
  - SEG_DIGIT constant array (10 x 7-bit patterns).
  - SEG_BLANK = 7'b1111111.
  - BCD_INVALID = 4'hE.
  - BCD_BLANK = 4'hF.
  - FSM state typedef {COLLECT, HOLD}.
- Sub-module seg7_to_bcd: combinational 7-bit pattern in, 4-bit nibble and error bit out, table-driven from seg7_pkg.
- The top level owns the sampler, counter, mask, staging, FSM and output registers.

Test Plan:
- Reset: assert i_rst mid-frame (two digits captured) -> all outputs 0 immediately; after release, a full new scan is required before o_valid.
- Nominal, DIGITS=4, STABLE_CYCLES=4: enables 0001/0010/0100/1000 each held 4 cycles with 1001111/0010010/0000110/1001100 -> o_valid=1, o_bcd=16'h4321, o_err=4'b0000.
- Glitch: digit 1 pattern held 3 cycles, then changed -> no capture of digit 1; o_valid stays 0 until digit 1 is held 4 stable cycles.
- Invalid pattern: digit 2 = 1111110 -> o_bcd[11:8]=4'hE, o_err=4'b0100.
- Backpressure:
  - i_ready=0, second full frame 8765 -> o_bcd stays 16'h4321 and o_overrun=1.
  - Then i_ready=1 for one cycle -> o_valid=0, o_overrun=0.
- Blank, with macro on/off: digit 3 = 1111111 -> defined: nibble F, o_err[3]=0; undefined: nibble E, o_err[3]=1.
